gestor_estado_mascota: RTL and testbench
========================================

Name: gestor_estado_mascota

Overview:
Consumer end of the level interface. Takes the four 2-bit need levels (animo, energia, descanso, medicina) and the 5-second action pulses produced by the mode counters. Resolves them into a single debounced pet state plus alarm signalling for the display and LED stage. Sits between the mode instances and the visual output logic.

Parameters:
ESTABLE_CICLOS, 8, consecutive cycles a candidate state must persist before it is committed.
ANIM_CICLOS, 16, duration in cycles of the COMIENDO/CURANDO action states and of each step in test sweep.
MUERTE_CICLOS, 32, consecutive cycles with all levels 0 before MUERTO.
PARPADEO_CICLOS, 4, half-period in cycles of the alarm blink.
TONO_CICLOS, 2, half-period of the buzzer tone (optional feature only).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
nivel_animo  in  2  animo level, 0..3
nivel_energia  in  2  energia level, 0..3
nivel_descanso  in  2  descanso level, 0..3
nivel_medicina  in  2  medicina level, 0..3
senal_5seg_energia  in  1  one-cycle pulse: feeding action completed
senal_5seg_medicina  in  1  one-cycle pulse: medicine action completed
test  in  1  one-cycle debounced test pulse
estado  out  3  committed state: FELIZ=0, NEUTRO=1, TRISTE=2, CANSADO=3, ENFERMO=4, COMIENDO=5, CURANDO=6, MUERTO=7
cambio_estado  out  1  one-cycle pulse on any change of estado
alarma  out  1  alarm indicator
zumbador  out  1  buzzer tone output

Behaviour:
- Reset (async): estado=NEUTRO, cambio_estado=0, alarma=0, zumbador=0. All counters 0. Test mode off. Death flag cleared.
- Levels are registered on input. Candidate evaluation uses the registered copies, giving 1 cycle input latency.
- Candidate state, by priority:
  - ENFERMO if medicina==0.
  - Else CANSADO if energia==0 or descanso==0.
  - Else TRISTE if animo==0.
  - Else FELIZ if all four levels >=2.
  - Else NEUTRO.
- Stability filter: a stable counter resets whenever the candidate differs from the previous cycle's candidate. estado takes the candidate when the counter reaches ESTABLE_CICLOS-1 with an unchanged candidate. Total latency from a level change to estado update is ESTABLE_CICLOS+1 cycles.
- Action override:
  - senal_5seg_energia forces estado=COMIENDO next cycle for ANIM_CICLOS cycles.
  - senal_5seg_medicina forces CURANDO for ANIM_CICLOS cycles.
  - Both pulses in the same cycle: CURANDO wins.
  - A new pulse during an action restarts the action timer with the new action.
  - When the action ends, estado takes the current candidate directly, without re-filtering.
  - The stable counter keeps running during an action.
- Death:
  - A death counter increments while all four registered levels are 0 and clears otherwise.
  - When it reaches MUERTE_CICLOS-1, estado=MUERTO, which is sticky until reset.
  - Action pulses and test pulses are ignored in MUERTO.
- Test mode:
  - A test pulse toggles test mode (ignored in MUERTO).
  - In test mode, estado sweeps 0,1,...,6,0,... advancing every ANIM_CICLOS cycles, starting at FELIZ on the cycle after entry. Levels and action pulses are ignored.
  - Exiting test mode loads the current candidate immediately.
- cambio_estado: high for exactly the cycle after the estado register changes value. Not asserted at reset.
- alarma:
  - In TRISTE, CANSADO or ENFERMO: square wave, toggling every PARPADEO_CICLOS cycles. The blink counter restarts at 0 with alarma=1 on entry to an alarm state.
  - In MUERTO: constantly 1.
  - Otherwise: 0.
- Counter widths use $clog2 of their parameter and saturate; they must not wrap.

Optional Feature:
SONIDO_ALARMA_EN.
- Defined: zumbador toggles every TONO_CICLOS cycles while alarma==1, and is 0 when alarma==0, in MUERTO, and in test mode.
- Undefined: zumbador is tied to 0 and no tone counter is synthesised.

Test Plan:
1. Reset, then all levels=3 held -> estado stays NEUTRO for ESTABLE_CICLOS+1 (9) cycles, then FELIZ with a one-cycle cambio_estado pulse.
2. medicina=0, energia=0 -> ENFERMO (priority over CANSADO) after 9 cycles. alarma shows 4 high / 4 low repeating.
3. Glitch: animo=0 for 5 cycles then back to 3 from FELIZ -> estado remains FELIZ and cambio_estado stays 0.
4. Both action pulses in the same cycle -> estado=CURANDO next cycle for 16 cycles, then returns to the candidate. A repeat senal_5seg_energia at cycle 10 -> COMIENDO for 16 more cycles.
5. All levels 0 for 32 cycles -> MUERTO, alarma=1. Then levels=3, plus test and action pulses -> stays MUERTO. Asserting reset asynchronously mid-cycle -> NEUTRO immediately.
6. Test pulse -> estado sweeps 0..6 at 16-cycle steps, wrapping to 0. A second test pulse -> candidate loaded next cycle. With SONIDO_ALARMA_EN defined, zumbador toggles every 2 cycles only while alarma==1.

Source files
------------

// File: rtl/gestor_estado_mascota.sv
// rtl/gestor_estado_mascota.sv - resolves need levels and action pulses into a debounced pet state with alarm
// Optional buzzer tone: define SONIDO_ALARMA_EN.
module gestor_estado_mascota #(
  parameter int ESTABLE_CICLOS  = 8,
  parameter int ANIM_CICLOS     = 16,
  parameter int MUERTE_CICLOS   = 32,
  parameter int PARPADEO_CICLOS = 4,
  parameter int TONO_CICLOS     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] nivel_animo,
  input  logic [1:0] nivel_energia,
  input  logic [1:0] nivel_descanso,
  input  logic [1:0] nivel_medicina,
  input  logic       senal_5seg_energia,
  input  logic       senal_5seg_medicina,
  input  logic       test,
  output logic [2:0] estado,
  output logic       cambio_estado,
  output logic       alarma,
  output logic       zumbador
);

  typedef enum logic [2:0] {
    FELIZ    = 3'd0,
    NEUTRO   = 3'd1,
    TRISTE   = 3'd2,
    CANSADO  = 3'd3,
    ENFERMO  = 3'd4,
    COMIENDO = 3'd5,
    CURANDO  = 3'd6,
    MUERTO   = 3'd7
  } estado_t;

  typedef enum logic [1:0] {
    M_NORMAL = 2'd0,
    M_ACCION = 2'd1,
    M_TEST   = 2'd2,
    M_MUERTO = 2'd3
  } modo_t;

  localparam int WE = (ESTABLE_CICLOS  > 1) ? $clog2(ESTABLE_CICLOS)  : 1;
  localparam int WA = (ANIM_CICLOS     > 1) ? $clog2(ANIM_CICLOS)     : 1;
  localparam int WM = (MUERTE_CICLOS   > 1) ? $clog2(MUERTE_CICLOS)   : 1;
  localparam int WP = (PARPADEO_CICLOS > 1) ? $clog2(PARPADEO_CICLOS) : 1;

  localparam logic [WE-1:0] EST_MAX  = WE'(ESTABLE_CICLOS - 1);
  localparam logic [WA-1:0] ANIM_MAX = WA'(ANIM_CICLOS - 1);
  localparam logic [WM-1:0] MUER_MAX = WM'(MUERTE_CICLOS - 1);
  localparam logic [WP-1:0] PARP_MAX = WP'(PARPADEO_CICLOS - 1);

  logic [1:0]    animo_q, energia_q, descanso_q, medicina_q;
  estado_t       cand, cand_q;
  estado_t       estado_q, estado_d;
  modo_t         modo_q, modo_d;
  logic [WE-1:0] est_cnt_q, est_cnt_d;
  logic [WM-1:0] muerte_cnt_q, muerte_cnt_d;
  logic [WA-1:0] anim_cnt_q, anim_cnt_d;
  logic [WP-1:0] parp_cnt_q, parp_cnt_d;
  logic          parp_fase_q, parp_fase_d;
  logic          cambio_q;
  logic          todos_cero, estable_ok, muere;

  function automatic logic es_alarma(estado_t e);
    return (e == TRISTE) || (e == CANSADO) || (e == ENFERMO);
  endfunction

  always_comb begin
    cand = NEUTRO;
    if (medicina_q == 2'd0)
      cand = ENFERMO;
    else if (energia_q == 2'd0 || descanso_q == 2'd0)
      cand = CANSADO;
    else if (animo_q == 2'd0)
      cand = TRISTE;
    else if (animo_q[1] && energia_q[1] && descanso_q[1] && medicina_q[1])
      cand = FELIZ;
  end

  assign todos_cero = (animo_q == 2'd0) && (energia_q == 2'd0) &&
                      (descanso_q == 2'd0) && (medicina_q == 2'd0);
  assign estable_ok = (cand == cand_q) && (est_cnt_q == EST_MAX);
  assign muere      = todos_cero && (muerte_cnt_q == MUER_MAX);

  always_comb begin
    est_cnt_d    = est_cnt_q;
    muerte_cnt_d = muerte_cnt_q;
    modo_d       = modo_q;
    estado_d     = estado_q;
    anim_cnt_d   = anim_cnt_q;
    parp_cnt_d   = '0;
    parp_fase_d  = 1'b0;

    // Both filters run in every mode so an action or test exit sees current history
    if (cand != cand_q)
      est_cnt_d = '0;
    else if (est_cnt_q != EST_MAX)
      est_cnt_d = est_cnt_q + 1'b1;

    if (!todos_cero)
      muerte_cnt_d = '0;
    else if (muerte_cnt_q != MUER_MAX)
      muerte_cnt_d = muerte_cnt_q + 1'b1;

    if (modo_q == M_MUERTO) begin
      estado_d = MUERTO;
    end else if (muere && modo_q != M_TEST) begin
      modo_d   = M_MUERTO;
      estado_d = MUERTO;
    end else if (test) begin
      if (modo_q == M_TEST) begin
        modo_d   = M_NORMAL;
        estado_d = cand;
      end else begin
        modo_d     = M_TEST;
        estado_d   = FELIZ;
        anim_cnt_d = '0;
      end
    end else if (modo_q == M_TEST) begin
      if (anim_cnt_q == ANIM_MAX) begin
        anim_cnt_d = '0;
        estado_d   = (estado_q == CURANDO) ? FELIZ : estado_t'(estado_q + 3'd1);
      end else begin
        anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end else if (senal_5seg_medicina) begin
      modo_d     = M_ACCION;
      estado_d   = CURANDO;
      anim_cnt_d = '0;
    end else if (senal_5seg_energia) begin
      modo_d     = M_ACCION;
      estado_d   = COMIENDO;
      anim_cnt_d = '0;
    end else if (modo_q == M_ACCION) begin
      if (anim_cnt_q == ANIM_MAX) begin
        modo_d   = M_NORMAL;
        estado_d = cand;
      end else begin
        anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end else if (estable_ok) begin
      estado_d = cand;
    end

    // Any change into an alarm state, even between two alarm states, restarts the blink high
    if (es_alarma(estado_d)) begin
      if (estado_d != estado_q) begin
        parp_fase_d = 1'b1;
      end else if (parp_cnt_q == PARP_MAX) begin
        parp_fase_d = ~parp_fase_q;
      end else begin
        parp_cnt_d  = parp_cnt_q + 1'b1;
        parp_fase_d = parp_fase_q;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      animo_q      <= 2'd0;
      energia_q    <= 2'd0;
      descanso_q   <= 2'd0;
      medicina_q   <= 2'd0;
      cand_q       <= NEUTRO;
      estado_q     <= NEUTRO;
      modo_q       <= M_NORMAL;
      est_cnt_q    <= '0;
      muerte_cnt_q <= '0;
      anim_cnt_q   <= '0;
      parp_cnt_q   <= '0;
      parp_fase_q  <= 1'b0;
      cambio_q     <= 1'b0;
    end else begin
      animo_q      <= nivel_animo;
      energia_q    <= nivel_energia;
      descanso_q   <= nivel_descanso;
      medicina_q   <= nivel_medicina;
      cand_q       <= cand;
      estado_q     <= estado_d;
      modo_q       <= modo_d;
      est_cnt_q    <= est_cnt_d;
      muerte_cnt_q <= muerte_cnt_d;
      anim_cnt_q   <= anim_cnt_d;
      parp_cnt_q   <= parp_cnt_d;
      parp_fase_q  <= parp_fase_d;
      cambio_q     <= (estado_d != estado_q);
    end
  end

  assign estado        = estado_q;
  assign cambio_estado = cambio_q;
  assign alarma        = (estado_q == MUERTO) || (es_alarma(estado_q) && parp_fase_q);

`ifdef SONIDO_ALARMA_EN
  localparam int WT = (TONO_CICLOS > 1) ? $clog2(TONO_CICLOS) : 1;
  localparam logic [WT-1:0] TONO_MAX = WT'(TONO_CICLOS - 1);

  logic [WT-1:0] tono_cnt_q;
  logic          tono_q;
  logic          tono_en;

  assign tono_en = alarma && (modo_q != M_MUERTO) && (modo_q != M_TEST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tono_cnt_q <= '0;
      tono_q     <= 1'b0;
    end else if (!tono_en) begin
      tono_cnt_q <= '0;
      tono_q     <= 1'b0;
    end else if (tono_cnt_q == TONO_MAX) begin
      tono_cnt_q <= '0;
      tono_q     <= ~tono_q;
    end else begin
      tono_cnt_q <= tono_cnt_q + 1'b1;
    end
  end

  // Gated so the tone drops in the same cycle alarma does
  assign zumbador = tono_q && tono_en;
`else
  assign zumbador = 1'b0 && (TONO_CICLOS > 0);
`endif

endmodule

// File: tb/tb_gestor_estado_mascota.sv
// tb/tb_gestor_estado_mascota.sv - randomized and directed check of gestor_estado_mascota against a behavioural model
module tb_gestor_estado_mascota;

  localparam int EST  = 8;
  localparam int ANIM = 16;
  localparam int MUER = 32;
  localparam int PARP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] na, ne, nd, nm;
  logic       pe, pm, tst;
  logic [2:0] estado;
  logic       cambio, alarma, zumb;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  int m_lv [4];
  int m_prev_cand, m_run, m_zero_run, m_test_t, m_act_rem, m_estado, m_since;
  bit m_dead, m_test, m_cambio;

  gestor_estado_mascota dut (
    .clk                 (clk),
    .reset               (reset),
    .nivel_animo         (na),
    .nivel_energia       (ne),
    .nivel_descanso      (nd),
    .nivel_medicina      (nm),
    .senal_5seg_energia  (pe),
    .senal_5seg_medicina (pm),
    .test                (tst),
    .estado              (estado),
    .cambio_estado       (cambio),
    .alarma              (alarma),
    .zumbador            (zumb)
  );

  always #5 clk = ~clk;

  function automatic int cand_of(int a, int e, int d, int m);
    if (m == 0) return 4;
    if (e == 0 || d == 0) return 3;
    if (a == 0) return 2;
    if (a >= 2 && e >= 2 && d >= 2 && m >= 2) return 0;
    return 1;
  endfunction

  function automatic int m_alarma();
    if (m_dead) return 1;
    if (m_estado >= 2 && m_estado <= 4) return ((m_since / PARP) % 2 == 0) ? 1 : 0;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_lv[i] = 0;
    m_prev_cand = 1; m_run = 1; m_zero_run = 0;
    m_test_t = 0; m_act_rem = 0; m_estado = 1; m_since = 0;
    m_dead = 0; m_test = 0; m_cambio = 0;
  endtask

  task automatic model_step();
    int  c, nxt;
    bit  allz;
    c = cand_of(m_lv[0], m_lv[1], m_lv[2], m_lv[3]);
    if (c == m_prev_cand) begin
      if (m_run < 100000) m_run++;
    end else m_run = 1;
    m_prev_cand = c;
    allz = (m_lv[0] == 0) && (m_lv[1] == 0) && (m_lv[2] == 0) && (m_lv[3] == 0);
    m_zero_run = allz ? m_zero_run + 1 : 0;
    nxt = m_estado;
    if (m_dead) nxt = 7;
    else if (!m_test && m_zero_run >= MUER) begin
      m_dead = 1; nxt = 7;
    end else if (tst) begin
      if (m_test) begin m_test = 0; nxt = c; end
      else begin m_test = 1; m_test_t = 0; m_act_rem = 0; nxt = 0; end
    end else if (m_test) begin
      m_test_t++; nxt = (m_test_t / ANIM) % 7;
    end else if (pm) begin
      m_act_rem = ANIM; nxt = 6;
    end else if (pe) begin
      m_act_rem = ANIM; nxt = 5;
    end else if (m_act_rem > 0) begin
      m_act_rem--;
      if (m_act_rem == 0) nxt = c;
    end else if (m_run >= EST + 1) nxt = c;
    m_cambio = (nxt != m_estado);
    m_since  = m_cambio ? 0 : m_since + 1;
    m_estado = nxt;
    m_lv[0] = int'(na); m_lv[1] = int'(ne); m_lv[2] = int'(nd); m_lv[3] = int'(nm);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        chk("estado", int'(estado), m_estado);
        chk("cambio_estado", int'(cambio), int'(m_cambio));
        chk("alarma", int'(alarma), m_alarma());
`ifdef SONIDO_ALARMA_EN
        if (m_alarma() == 0 || m_dead || m_test) chk("zumbador_off", int'(zumb), 0);
`else
        chk("zumbador", int'(zumb), 0);
`endif
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_lv(input int a, input int e, input int d, input int m);
    na = 2'(a); ne = 2'(e); nd = 2'(d); nm = 2'(m);
  endtask

  task automatic pulse(input bit p_e, input bit p_m, input bit p_t);
    pe = p_e; pm = p_m; tst = p_t;
    @(negedge clk);
    pe = 1'b0; pm = 1'b0; tst = 1'b0;
  endtask

  task automatic run_random(input int n);
    int  hold;
    bit  was_zero;
    hold = 0; was_zero = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (hold == 0) begin
        set_lv($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        if (was_zero && na == 0 && ne == 0 && nd == 0 && nm == 0) nm = 2'd2;
        was_zero = (na == 0 && ne == 0 && nd == 0 && nm == 0);
        hold = $urandom_range(1, 20);
      end
      hold--;
      pe  = ($urandom_range(0, 99) < 2);
      pm  = ($urandom_range(0, 99) < 2);
      tst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    pe = 1'b0; pm = 1'b0; tst = 1'b0;
  endtask

  initial begin
    int n;
    set_lv(3, 3, 3, 3);
    pe = 1'b0; pm = 1'b0; tst = 1'b0;
    reset = 1'b1;
    wait_cycles(3);
    cmp_en = 1'b1;
    chk("reset_estado", int'(estado), 1);
    chk("reset_alarma", int'(alarma), 0);
    reset = 1'b0;

    wait_cycles(9);
    chk("p1_neutro", int'(estado), 1);
    wait_cycles(1);
    chk("p1_feliz", int'(estado), 0);
    chk("p1_pulse", int'(cambio), 1);
    wait_cycles(1);
    chk("p1_pulse_end", int'(cambio), 0);

    set_lv(3, 0, 3, 0);
    wait_cycles(9);
    chk("p2_still_feliz", int'(estado), 0);
    wait_cycles(1);
    chk("p2_enfermo", int'(estado), 4);
    chk("p2_alarm_on", int'(alarma), 1);
    wait_cycles(4);
    chk("p2_alarm_off", int'(alarma), 0);
    wait_cycles(4);
    chk("p2_alarm_on2", int'(alarma), 1);

    set_lv(3, 3, 3, 3);
    wait_cycles(12);
    na = 2'd0;
    wait_cycles(5);
    na = 2'd3;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (cambio) n++;
    end
    chk("p3_no_change", n, 0);
    chk("p3_feliz", int'(estado), 0);

    pulse(1'b1, 1'b1, 1'b0);
    chk("p4_curando", int'(estado), 6);
    wait_cycles(8);
    pulse(1'b1, 1'b0, 1'b0);
    chk("p4_comiendo", int'(estado), 5);
    wait_cycles(15);
    chk("p4_comiendo_end", int'(estado), 5);
    wait_cycles(1);
    chk("p4_back", int'(estado), 0);

    pulse(1'b0, 1'b0, 1'b1);
    chk("p6_sweep0", int'(estado), 0);
    na = 2'd0;
    wait_cycles(16);
    chk("p6_sweep1", int'(estado), 1);
    wait_cycles(80);
    chk("p6_sweep6", int'(estado), 6);
    wait_cycles(16);
    chk("p6_wrap", int'(estado), 0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("p6_exit", int'(estado), 2);
    na = 2'd3;

    run_random(3000);
    set_lv(3, 3, 3, 3);
    wait_cycles(40);
    if (m_test) pulse(1'b0, 1'b0, 1'b1);
    wait_cycles(12);

    set_lv(0, 0, 0, 0);
    wait_cycles(32);
    chk("p5_enfermo_pre", int'(estado), 4);
    wait_cycles(1);
    chk("p5_muerto", int'(estado), 7);
    chk("p5_alarma", int'(alarma), 1);
    set_lv(3, 3, 3, 3);
    pulse(1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b1, 1'b0);
    wait_cycles(20);
    chk("p5_sticky", int'(estado), 7);

    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("p5_async_neutro", int'(estado), 1);
    chk("p5_async_cambio", int'(cambio), 0);
    chk("p5_async_alarma", int'(alarma), 0);
    @(negedge clk);
    reset = 1'b0;

    run_random(1500);
    wait_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
